apb_cmd_master: RTL
===================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning ACCESS-phase wait cycles allowed before abort (used only with APB_CMD_MASTER_TIMEOUT_EN).
REQ-002 PCLK  in  1  clock; all state updates on rising edge.
REQ-003 PRESETn  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  32  byte address.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 cmd_strb  in  4  byte-lane write strobes.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
REQ-012 rsp_rdata  out  32  read data; 0 for writes and aborts.
REQ-013 rsp_err  out  1  PSLVERR captured, or timeout.
REQ-014 rsp_timeout  out  1  transfer aborted by timeout.
REQ-015 PSEL, PENABLE, PWRITE  out  1 each; PADDR  out  32; PWDATA  out  32; PSTRB  out  4 -- APB requester outputs, all registered.
REQ-016 PRDATA  in  32; PREADY  in  1; PSLVERR  in  1 -- APB completer inputs.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP; one transfer outstanding at a time.
REQ-018 cmd_ready SHALL equal (state == IDLE), combinationally.
REQ-019 On acceptance, the block SHALL register cmd_write/addr/wdata onto PWRITE/PADDR/PWDATA, register PSTRB = cmd_strb for writes and 4'b0000 for reads, and enter SETUP.
REQ-020 In SETUP, PSEL SHALL be 1 and PENABLE 0 for exactly one cycle; next state ACCESS.
REQ-021 In ACCESS, PSEL = 1 and PENABLE = 1, held until PREADY = 1 is sampled at a rising edge.
REQ-022 PADDR, PWRITE, PWDATA, PSTRB SHALL remain stable from SETUP through the final ACCESS cycle.
REQ-023 On PREADY = 1 in ACCESS, the block SHALL capture rsp_rdata = PRDATA (reads) or 0 (writes), set rsp_err = PSLVERR and rsp_timeout = 0, deassert PSEL/PENABLE, and enter RESP.
REQ-024 In RESP, rsp_valid = 1 and rsp_* SHALL be held stable until rsp_ready = 1; then return to IDLE with rsp_valid = 0.
REQ-025 Latency: with a zero-wait completer, accept at cycle T gives SETUP at T+1, ACCESS at T+2, and rsp_valid at T+3; each completer wait state adds one cycle.
REQ-026 A cmd_valid held during SETUP, ACCESS or RESP SHALL NOT be accepted and SHALL wait until IDLE.
REQ-027 rsp_ready = 1 while not in RESP SHALL be ignored.
REQ-028 PREADY and PSLVERR SHALL be ignored outside ACCESS.
REQ-029 In IDLE and RESP, PSEL = PENABLE = 0; PADDR/PWDATA/PWRITE/PSTRB retain their last values.

Reset
REQ-030 When PRESETn = 0, the block SHALL immediately enter IDLE and drive PSEL = PENABLE = PWRITE = 0, PADDR = PWDATA = 0, PSTRB = 0, rsp_valid = rsp_err = rsp_timeout = 0, rsp_rdata = 0, and clear the wait counter.
REQ-031 A reset during SETUP, ACCESS or RESP SHALL drop the transfer without producing any response.

Configuration
REQ-032 With APB_CMD_MASTER_TIMEOUT_EN defined: a counter SHALL clear on entering ACCESS and increment each ACCESS cycle with PREADY = 0; on reaching TIMEOUT_CYCLES, the block SHALL abort (PSEL = PENABLE = 0) and enter RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
REQ-033 PREADY = 1 in the same cycle the count reaches TIMEOUT_CYCLES SHALL complete normally; PREADY takes priority over timeout.
REQ-034 Without APB_CMD_MASTER_TIMEOUT_EN: no counter is built, ACCESS waits indefinitely, and rsp_timeout SHALL be constant 0.

Verification
REQ-035 Write addr 0x10, wdata 0xA5A5_1234, strb 0xF, completer with one wait state -> PSEL/PENABLE pattern 10,11,11; PSTRB = 0xF; rsp_valid at T+4; rsp_err = 0; rsp_rdata = 0.
REQ-036 Read addr 0x10 after REQ-035 -> PSTRB = 0; rsp_rdata = 0xA5A5_1234; rsp_err = 0.
REQ-037 Read addr 0x100 with completer returning PSLVERR = 1 -> rsp_err = 1; rsp_timeout = 0.
REQ-038 cmd_valid held continuously with rsp_ready = 0 for 5 cycles -> cmd_ready = 0 and rsp_* stable throughout; next command accepted only after the rsp handshake.
REQ-039 Macro defined, TIMEOUT_CYCLES = 4, PREADY tied 0 -> abort after 4 ACCESS cycles; rsp_err = 1; rsp_timeout = 1. Macro undefined -> PSEL held indefinitely.
REQ-040 PRESETn pulsed low during ACCESS -> PSEL = PENABLE = 0 asynchronously; no rsp_valid; cmd_ready = 1 after release.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB requester/completer signals bundled
// for apb_cmd_master. The master modport is the bridge's view; the slave
// modport is the view of whatever sits on the other side: the command source,
// the response sink and the APB completer.
interface apb_cmd_master_if;
    // command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    // response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    // APB bus
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns one valid/ready command at a time into an APB
// SETUP/ACCESS transfer and returns the result on a valid/ready response
// channel. All APB outputs come straight from flops.
// Optional feature: define APB_CMD_MASTER_TIMEOUT_EN to abort an ACCESS
// phase after TIMEOUT_CYCLES wait cycles (rsp_err = rsp_timeout = 1).
module apb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic             PCLK,
    input logic             PRESETn,
    apb_cmd_master_if.master bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t      state_reg, state_next;
    logic        psel_reg, psel_next;
    logic        penable_reg, penable_next;
    logic        pwrite_reg, pwrite_next;
    logic [31:0] paddr_reg, paddr_next;
    logic [31:0] pwdata_reg, pwdata_next;
    logic [3:0]  pstrb_reg, pstrb_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_err_reg, rsp_err_next;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             rsp_timeout_reg, rsp_timeout_next;
    logic             timeout_hit;

    // The wait cycle now ending is the one that brings the count to the limit.
    assign timeout_hit     = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.rsp_timeout = rsp_timeout_reg;
`else
    // No timeout hardware: the parameter is accepted but has no effect.
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CYCLES > 0);
    assign bus.rsp_timeout      = 1'b0;
`endif

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.PSEL      = psel_reg;
    assign bus.PENABLE   = penable_reg;
    assign bus.PWRITE    = pwrite_reg;
    assign bus.PADDR     = paddr_reg;
    assign bus.PWDATA    = pwdata_reg;
    assign bus.PSTRB     = pstrb_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;

    // State and output registers; reset drops any transfer in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg       <= IDLE;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            pstrb_reg       <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            wait_cnt_reg    <= '0;
            rsp_timeout_reg <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            pwrite_reg      <= pwrite_next;
            paddr_reg       <= paddr_next;
            pwdata_reg      <= pwdata_next;
            pstrb_reg       <= pstrb_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            wait_cnt_reg    <= wait_cnt_next;
            rsp_timeout_reg <= rsp_timeout_next;
`endif
        end
    end

    // Next-state and next-output logic; everything holds unless a branch changes it.
    always_comb begin
        state_next       = state_reg;
        psel_next        = psel_reg;
        penable_next     = penable_reg;
        pwrite_next      = pwrite_reg;
        paddr_next       = paddr_reg;
        pwdata_next      = pwdata_reg;
        pstrb_next       = pstrb_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        wait_cnt_next    = wait_cnt_reg;
        rsp_timeout_next = rsp_timeout_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_next   = SETUP;
                    psel_next    = 1'b1;
                    penable_next = 1'b0;
                    pwrite_next  = bus.cmd_write;
                    paddr_next   = bus.cmd_addr;
                    pwdata_next  = bus.cmd_wdata;
                    // reads never carry strobes
                    pstrb_next   = bus.cmd_write ? bus.cmd_strb : 4'b0000;
                end
            end
            SETUP: begin
                state_next    = ACCESS;
                penable_next  = 1'b1;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                wait_cnt_next = '0;
`endif
            end
            ACCESS: begin
                // PREADY wins over a timeout landing in the same cycle
                if (bus.PREADY) begin
                    state_next       = RESP;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_rdata_next   = pwrite_reg ? 32'h0 : bus.PRDATA;
                    rsp_err_next     = bus.PSLVERR;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    rsp_timeout_next = 1'b0;
                end else if (timeout_hit) begin
                    state_next       = RESP;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_rdata_next   = 32'h0;
                    rsp_err_next     = 1'b1;
                    rsp_timeout_next = 1'b1;
                end else begin
                    wait_cnt_next    = wait_cnt_reg + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
